serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor built on a chain of 1-bit full-adder cells.
- Processes BITS_PER_CYCLE operand bits per clock, LSB first, and carries between steps in a register.
- Uses a valid/ready handshake on input and output so it can sit between register stages in arithmetic datapaths.
- Replaces the purely combinational single-bit adder where width must scale without a wide ripple path.

Parameters:
- WIDTH, 8: operand and result width in bits; must be at least 1.
- BITS_PER_CYCLE, 1: bits summed per clock; must divide WIDTH exactly. STEPS = WIDTH/BITS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (borrow-in when sub=1)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out; in subtract mode 1 means no borrow
- ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, in_ready=1, out_valid=0.
  - sum, cout, ovf, step counter and internal shift/carry registers all 0.
  - Release is synchronous to clk.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready:
    - latch a into the A register;
    - latch (sub ? ~b : b) into the B register;
    - carry register = sub ? ~cin : cin;
    - counter=0; go to ADD.
- ADD:
  - in_ready=0; in_valid is ignored.
  - Each cycle, the low BITS_PER_CYCLE bits of A/B plus the carry register pass through BITS_PER_CYCLE chained full-adder cells.
  - The result bits shift into the result register from the MSB end; A/B shift right by BITS_PER_CYCLE.
  - Carry register takes the cell-chain carry-out; counter increments.
  - After the step with counter==STEPS-1, go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable while out_ready=0.
  - On out_ready, go to IDLE at that edge.
  - No accept in the same cycle: in_ready rises the cycle after the handshake.
- Latency:
  - out_valid rises exactly STEPS clocks after the accepting edge.
  - Throughput is one operation per STEPS+2 cycles when out_ready is held high.
- Arithmetic:
  - Modulo 2^WIDTH.
  - cout = carry out of bit WIDTH-1.
  - Subtract is a + ~b + ~cin. For example, a-b with cin=0 yields a + ~b + 1.
- Boundaries:
  - in_valid outside IDLE is ignored; operands are not queued.
  - out_ready outside DONE is ignored.
  - Reset asserted mid-ADD or mid-DONE aborts the operation; the result is discarded and out_valid drops immediately.
  - WIDTH=BITS_PER_CYCLE gives STEPS=1.
  - Counter width is clog2(STEPS), minimum 1.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined: ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. It is captured in the last ADD step and held through DONE.
- Undefined: ovf is tied to 0 and no extra flop is inferred. The port list is identical in both builds.

Decomposition:
- Package serial_adder_pkg holds:
  - the state encoding (IDLE=2'd0, ADD=2'd1, DONE=2'd2);
  - a constant function computing STEPS and counter width.
- One natural sub-module, fa_cell: combinational 1-bit full adder (a, b, ci -> s, co).
  - Instantiated BITS_PER_CYCLE times in a generate loop.
  - The carry into the top cell is exposed for the ovf calculation.

Test Plan:
- WIDTH=8, BPC=1, a=0x5A, b=0x3C, cin=0, sub=0 -> sum=0x96, cout=0, ovf=1 (with macro), out_valid exactly 8 clocks after accept.
- a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0; then a=0x7F, b=0x00, cin=1 -> sum=0x80, ovf=1.
- sub=1, a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=0; sub=1, a=0x20, b=0x10 -> sum=0x10, cout=1.
- Backpressure: out_ready low 5 cycles in DONE -> sum/cout stable, in_ready=0, and a second in_valid pulse is not accepted; the first op completes once out_ready rises.
- Reset mid-ADD: drop rst_n at step 3 -> out_valid=0, sum=0, in_ready=1 after release; a new op 0x01+0x01 -> 0x02.
- WIDTH=8, BPC=4, a=0xC8, b=0x64, cin=1 -> sum=0x2D, cout=1, latency 2 clocks; WIDTH=8, BPC=8 -> latency 1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM encoding and sizing helpers.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of clock steps needed to consume a full operand.
    function automatic int unsigned calc_steps(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

    // Step counter width: clog2(steps), never narrower than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder used as the building block of the step chain.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB first,
// carry held in a register between steps, valid/ready on both sides.
// Optional build macro SERIAL_ADDER_OVF_EN enables the signed-overflow flag;
// without it ovf is tied low and no flop is built for it.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned BPC   = BITS_PER_CYCLE;
    localparam int unsigned STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CNT_W = calc_cnt_w(STEPS);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [BPC:0]     chain_c;
    logic [BPC-1:0]   step_s;
    logic             last_step;

    // Carry chain for one step: the registered carry feeds the bottom cell.
    assign chain_c[0] = carry_q;

    for (genvar g = 0; g < int'(BPC); g++) begin : g_cell
        fa_cell u_fa (
            .a  (a_q[g]),
            .b  (b_q[g]),
            .ci (chain_c[g]),
            .s  (step_s[g]),
            .co (chain_c[g+1])
        );
    end

    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                res_d   = (res_q >> BPC) | (WIDTH'(step_s) << (WIDTH - BPC));
                carry_d = chain_c[BPC];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_step) begin
                    cout_d  = chain_c[BPC];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow = carry into MSB xor carry out of MSB, taken on the final step.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == ST_ADD) && last_step) begin
            ovf_d = chain_c[BPC] ^ chain_c[BPC-1];
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = res_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: BPC=1 main instance plus BPC=4 and BPC=8.
module tb_serial_adder;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       cin, sub;

    logic       iv1, ir1, ov1, or1, co1, ovf1;
    logic [7:0] s1;
    logic       iv4, ir4, ov4, or4, co4, ovf4;
    logic [7:0] s4;
    logic       iv8, ir8, ov8, or8, co8, ovf8;
    logic [7:0] s8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(or1), .sum(s1),
        .cout(co1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(or4), .sum(s4),
        .cout(co4), .ovf(ovf4)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(ovf8)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present operands to the BPC=1 instance and return after the accept edge.
    task automatic accept1(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
        int n = 0;
        while (!ir1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", 32'(ir1), 32'd1);
        a = ta; b = tb; cin = tc; sub = ts; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        check("busy_after_accept", 32'(ir1), 32'd0);
    endtask

    // Count edges until out_valid on the BPC=1 instance and check the latency.
    task automatic wait_valid1(input string tag, input int exp_lat);
        int lat = 0;
        while (!ov1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // Full transaction on the BPC=1 instance with immediate consumption.
    task automatic run1(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts,
                        input logic [7:0] esum, input logic ecout, input logic eovf);
        accept1(ta, tb, tc, ts);
        wait_valid1(tag, 8);
        check({tag, "_sum"},  32'(s1),   32'(esum));
        check({tag, "_cout"}, 32'(co1),  32'(ecout));
        check({tag, "_ovf"},  32'(ovf1), 32'(eovf & OVF_ON));
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        check({tag, "_drop"}, 32'(ov1), 32'd0);
    endtask

    // Transaction on a wide-step instance (sel 4 or 8); out_ready is held high.
    task automatic run_wide(input int sel, input string tag, input logic [7:0] ta,
                            input logic [7:0] tb, input logic tc, input logic ts,
                            input logic [7:0] esum, input logic ecout, input logic eovf,
                            input int exp_lat);
        int lat = 0;
        a = ta; b = tb; cin = tc; sub = ts;
        if (sel == 4) iv4 = 1'b1; else iv8 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; iv8 = 1'b0;
        while (!((sel == 4) ? ov4 : ov8) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"},  32'(lat), 32'(exp_lat));
        check({tag, "_sum"},  32'((sel == 4) ? s4 : s8),     32'(esum));
        check({tag, "_cout"}, 32'((sel == 4) ? co4 : co8),   32'(ecout));
        check({tag, "_ovf"},  32'((sel == 4) ? ovf4 : ovf8), 32'(eovf & OVF_ON));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv1 = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
        or1 = 1'b0; or4 = 1'b1; or8 = 1'b1;
        #12;
        check("rst_in_ready",  32'(ir1),  32'd1);
        check("rst_out_valid", 32'(ov1),  32'd0);
        check("rst_sum",       32'(s1),   32'd0);
        check("rst_cout",      32'(co1),  32'd0);
        check("rst_ovf",       32'(ovf1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run1("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        run1("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run1("add7f00", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        run1("sub1020", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        run1("sub2010", 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);

        // Backpressure: result held, second request ignored.
        accept1(8'h33, 8'h44, 1'b0, 1'b0);
        wait_valid1("bp", 8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a = 8'hAA; b = 8'h11; iv1 = 1'b1;
            end else begin
                iv1 = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_sum",   32'(s1),  32'h77);
            check("bp_cout",  32'(co1), 32'd0);
            check("bp_valid", 32'(ov1), 32'd1);
            check("bp_ready", 32'(ir1), 32'd0);
        end
        iv1 = 1'b0;
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        check("bp_release_valid", 32'(ov1), 32'd0);
        check("bp_release_ready", 32'(ir1), 32'd1);
        @(posedge clk); #1;
        check("bp_no_queue", 32'(ir1), 32'd1);

        // Reset in the middle of ADD.
        accept1(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(ov1), 32'd0);
        check("midrst_ready", 32'(ir1), 32'd1);
        check("midrst_sum",   32'(s1),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_ready", 32'(ir1), 32'd1);
        check("postrst_valid", 32'(ov1), 32'd0);
        run1("add0101", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        run_wide(4, "bpc4", 8'hC8, 8'h64, 1'b1, 1'b0, 8'h2D, 1'b1, 1'b0, 2);
        run_wide(8, "bpc8", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
